// File: rtl/solver_ram_pkg.sv
// solver_ram_pkg: RAM geometry, loader FSM states and the
// wrapping address increment shared by the stream loader.
package solver_ram_pkg;

  localparam int SOLVER_RAM_DEPTH  = 6000;
  localparam int SOLVER_RAM_ADDR_W = 13;
  localparam int SOLVER_RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP,
    FIN
  } state_t;

  // Next word address; wraps to 0 after depth-1.
  function automatic logic [SOLVER_RAM_ADDR_W-1:0] wrap_inc(
    input logic [SOLVER_RAM_ADDR_W-1:0] a,
    input int                           depth
  );
    if (int'(a) == depth - 1) return '0;
    return a + SOLVER_RAM_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/solver_ram_skid_fifo.sv
// solver_ram_skid_fifo: 2-entry FIFO absorbing RAM read data.
// Ports: push/push_data in, pop in, head/count out.
module solver_ram_skid_fifo
  import solver_ram_pkg::*;
#(
  parameter int DATA_W = SOLVER_RAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/solver_ram_stream_loader.sv
// solver_ram_stream_loader: Avalon-ST <-> single-port RAM bridge.
// Ports: start/mode/base_addr/word_count command, busy/done/err/
// short_pkt status, snk_* load stream, src_* dump stream, ram_*
// RAM master. SOLVER_RAM_LOADER_CHECKSUM_EN adds checksum[31:0].
module solver_ram_stream_loader
  import solver_ram_pkg::*;
#(
  parameter int DEPTH  = SOLVER_RAM_DEPTH,
  parameter int ADDR_W = SOLVER_RAM_ADDR_W,
  parameter int DATA_W = SOLVER_RAM_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   word_count,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                short_pkt,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_valid,
  output logic                snk_ready,
  input  logic                snk_eop,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_sop,
  output logic                src_eop,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
`ifdef SOLVER_RAM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     iss_q, iss_d;
  logic              first_q, first_d;
  logic              infl_q, infl_d;
  logic              short_q, short_d;
  logic              err_q, err_d;

  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic [2:0]        occ;
  logic              bad_cmd, beat, issue, pop;

  assign bad_cmd = (base_addr >= ADDR_W'(DEPTH))
                || (word_count > ADDR_W'(DEPTH));

  assign occ       = {1'b0, fifo_cnt} + {2'b0, infl_q};
  assign src_valid = (fifo_cnt != 2'd0);
  assign pop       = src_valid && src_ready;
  assign beat      = (state_q == LOAD) && snk_valid;

  // A pop in the same cycle frees a slot, which keeps the
  // read pipe full at one word per clock.
  assign issue = (state_q == DUMP) && (iss_q != '0)
              && ((occ < 3'd2) || pop);

  solver_ram_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (infl_q),
    .push_data(ram_readdata),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    iss_d   = iss_q;
    first_d = first_q;
    short_d = short_q;
    err_d   = 1'b0;
    infl_d  = issue;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_cmd) begin
            err_d = 1'b1;
          end else begin
            short_d = 1'b0;
            ptr_d   = base_addr;
            rem_d   = CW'(word_count);
            iss_d   = CW'(word_count);
            first_d = 1'b1;
            if (word_count == '0) state_d = FIN;
            else if (mode)        state_d = DUMP;
            else                  state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          ptr_d = wrap_inc(ptr_q, DEPTH);
          rem_d = rem_q - ONE;
          if (rem_q == ONE) begin
            state_d = FIN;
          end else if (snk_eop) begin
            state_d = FIN;
            short_d = 1'b1;
          end
        end
      end
      DUMP: begin
        if (issue) begin
          ptr_d = wrap_inc(ptr_q, DEPTH);
          iss_d = iss_q - ONE;
        end
        if (pop) begin
          first_d = 1'b0;
          rem_d   = rem_q - ONE;
          if (rem_q == ONE) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      iss_q   <= '0;
      first_q <= 1'b0;
      infl_q  <= 1'b0;
      short_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      iss_q   <= iss_d;
      first_q <= first_d;
      infl_q  <= infl_d;
      short_q <= short_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == LOAD) || (state_q == DUMP);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign short_pkt = short_q;
  assign snk_ready = (state_q == LOAD);

  assign ram_chipselect = beat || issue;
  assign ram_write      = beat;
  assign ram_address    = (beat || issue) ? ptr_q : '0;
  assign ram_writedata  = beat ? snk_data : '0;
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;

  assign src_data = src_valid ? fifo_head : '0;
  assign src_sop  = src_valid && first_q;
  assign src_eop  = src_valid && (rem_q == ONE);

`ifdef SOLVER_RAM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
  logic        accept;

  assign accept = (state_q == IDLE) && start && !bad_cmd;

  always_comb begin
    csum_d = csum_q;
    if (accept)    csum_d = '0;
    else if (beat) csum_d = csum_q + 32'(snk_data);
    else if (pop)  csum_d = csum_q + 32'(src_data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule
